// File: rtl/key_pulse_array.sv
// key_pulse_array
//   Conditions N raw board keys for the control FSMs. Every channel goes
//   through a polarity normaliser, a synchroniser and a debouncer. Each
//   accepted press produces a one-cycle press pulse, and each accepted
//   release produces a one-cycle release pulse.
//
//   Optional feature (macro KEY_PULSE_REPEAT_EN): while a key stays held,
//   the press pulse auto-repeats REPEAT_DELAY cycles after the original
//   press pulse, and then every REPEAT_PERIOD cycles.
//
// Ports
//   clk            in   1       system clock, posedge
//   reset          in   1       asynchronous, active-high
//   keys_in        in   N_KEYS  raw key pins, polarity set by ACTIVE_LOW
//   pressed        out  N_KEYS  debounced level, 1 = held
//   press_pulse    out  N_KEYS  one-cycle pulse per accepted press (plus repeats)
//   release_pulse  out  N_KEYS  one-cycle pulse per accepted release
//   any_press      out  1       OR of press_pulse, same cycle
//
// All outputs are registered.

module key_pulse_array #(
  parameter int N_KEYS          = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_in,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic              any_press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES > 2 ? DEBOUNCE_CYCLES : 2);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Normalise before the synchroniser so that a reset value of 0 means
  // "released" regardless of pin polarity.
  logic [N_KEYS-1:0] norm;
  assign norm = (ACTIVE_LOW != 0) ? ~keys_in : keys_in;

  logic [N_KEYS-1:0] sync_q [SYNC_STAGES];
  logic [N_KEYS-1:0] s;
  assign s = sync_q[SYNC_STAGES-1];

  logic [DB_W-1:0]   db_cnt [N_KEYS];
  logic [N_KEYS-1:0] db_done;   // debounced level flips on this edge
  logic [N_KEYS-1:0] rep_fire;  // auto-repeat pulse due on this edge
  logic [N_KEYS-1:0] press_next;

  always_comb begin
    db_done = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      db_done[i] = (s[i] != pressed[i]) && (db_cnt[i] == DB_LAST);
    end
    // A flip with s=1 is a press; repeats share the same output bit.
    press_next = (db_done & s) | rep_fire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < N_KEYS; i++) db_cnt[i] <= '0;
      pressed       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      any_press     <= 1'b0;
    end else begin
      sync_q[0] <= norm;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < N_KEYS; i++) begin
        if (s[i] == pressed[i]) begin
          db_cnt[i] <= '0;
        end else if (db_done[i]) begin
          pressed[i] <= s[i];
          db_cnt[i]  <= '0;
        end else begin
          // Stays below DB_LAST here, so the counter cannot wrap.
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      press_pulse   <= press_next;
      release_pulse <= db_done & ~s;
      any_press     <= |press_next;
    end
  end

`ifdef KEY_PULSE_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX > 2 ? RP_MAX : 2);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

  logic [RP_W-1:0]   rep_cnt [N_KEYS];
  logic [N_KEYS-1:0] rep_first;  // still waiting for the first (longer) delay

  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      // No repeat on the edge where a release is accepted.
      rep_fire[i] = pressed[i] && !db_done[i] &&
                    (rep_first[i] ? (rep_cnt[i] == RD_LAST) : (rep_cnt[i] == RP_LAST));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_KEYS; i++) rep_cnt[i] <= '0;
      rep_first <= '1;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (db_done[i] || !pressed[i]) begin
          // Press pulse starts the count; release clears it.
          rep_cnt[i]   <= '0;
          rep_first[i] <= 1'b1;
        end else if (rep_fire[i]) begin
          rep_cnt[i]   <= '0;
          rep_first[i] <= 1'b0;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rep_fire = '0;
  // Repeat parameters have no effect in this build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

endmodule
